// File: rtl/i2s_tdm_rx.sv
// Parametrised I2S / TDM serial audio receiver.
// Deserialises a full frame and publishes all channels with one valid strobe.
module i2s_tdm_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int MODE       = 0,
    parameter int WS_EDGE    = 0
) (
    input  logic                         sclk_i,
    input  logic                         rst_i,
    input  logic                         ws_i,
    input  logic                         sdata_i,
    input  logic                         clrErr_i,
    output logic [NUM_CH*DATA_WIDTH-1:0] chData_o,
    output logic                         frameValid_o,
    output logic                         frameErr_o,
    output logic                         errSticky_o,
    output logic                         locked_o
);

    localparam int FRAME_LEN = NUM_CH * SLOT_WIDTH;
    localparam int PW        = $clog2(FRAME_LEN + 2);
    localparam int CW        = NUM_CH * DATA_WIDTH;

    localparam logic [PW-1:0] LEN_P = PW'(FRAME_LEN);
    localparam logic [PW-1:0] SAT_P = PW'(FRAME_LEN + 1);

    typedef enum logic {
        SYNC,
        RUN
    } state_t;

    state_t          state;
    logic            ws_q;
    logic [PW-1:0]   period;
    logic [CW-1:0]   shreg;
    logic [CW-1:0]   shreg_nxt;
    logic [CW-1:0]   publish;
    logic            fe;
    logic            cap_en;
    int              pos;

    always_comb begin
        if (WS_EDGE != 0) begin
            fe = !ws_q && ws_i;
        end else begin
            fe = ws_q && !ws_i;
        end
    end

    // Bit position within the frame; left-justified starts on the edge itself
    always_comb begin
        if (MODE == 0) begin
            pos    = int'(period) - 1;
            cap_en = (state == RUN);
        end else begin
            pos    = fe ? 0 : int'(period);
            cap_en = (state == RUN) || fe;
        end
    end

    always_comb begin
        shreg_nxt = shreg;
        if (cap_en && pos >= 0 && pos < FRAME_LEN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (pos >= k * SLOT_WIDTH &&
                    pos < k * SLOT_WIDTH + DATA_WIDTH) begin
                    shreg_nxt[k*DATA_WIDTH +: DATA_WIDTH] =
                        {shreg[k*DATA_WIDTH +: DATA_WIDTH-1], sdata_i};
                end
            end
        end
    end

    // In I2S mode the edge cycle still carries the previous frame's last bit
    always_comb begin
        if (MODE == 0) begin
            publish = shreg_nxt;
        end else begin
            publish = shreg;
        end
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            state        <= SYNC;
            ws_q         <= 1'b0;
            period       <= '0;
            shreg        <= '0;
            chData_o     <= '0;
            frameValid_o <= 1'b0;
            frameErr_o   <= 1'b0;
            errSticky_o  <= 1'b0;
            locked_o     <= 1'b0;
        end else begin
            ws_q         <= ws_i;
            shreg        <= shreg_nxt;
            frameValid_o <= 1'b0;
            frameErr_o   <= 1'b0;

            if (clrErr_i) begin
                errSticky_o <= 1'b0;
            end

            if (fe) begin
                period <= PW'(1);
            end else if (period != SAT_P) begin
                period <= period + 1'b1;
            end

            unique case (state)
                SYNC: begin
                    if (fe) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fe) begin
                        if (period == LEN_P) begin
                            chData_o     <= publish;
                            frameValid_o <= 1'b1;
                            locked_o     <= 1'b1;
                        end else begin
                            frameErr_o  <= 1'b1;
                            errSticky_o <= 1'b1;
                            locked_o    <= 1'b0;
                        end
                    end else if (period == LEN_P) begin
                        // Next cycle would exceed the frame: ws has stalled
                        frameErr_o  <= 1'b1;
                        errSticky_o <= 1'b1;
                        locked_o    <= 1'b0;
                        state       <= SYNC;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Directed bench for i2s_tdm_rx: default I2S stereo instance
// and a left-justified 4-slot TDM instance.
module tb_i2s_tdm_rx;

    logic        sclk;
    logic        rst_a, ws_a, sd_a, clr_a;
    logic [31:0] chData_a;
    logic        frameValid_a, frameErr_a, errSticky_a, locked_a;

    logic        rst_b, ws_b, sd_b, clr_b;
    logic [95:0] chData_b;
    logic        frameValid_b, frameErr_b, errSticky_b, locked_b;

    i2s_tdm_rx dut_a (
        .sclk_i       (sclk),
        .rst_i        (rst_a),
        .ws_i         (ws_a),
        .sdata_i      (sd_a),
        .clrErr_i     (clr_a),
        .chData_o     (chData_a),
        .frameValid_o (frameValid_a),
        .frameErr_o   (frameErr_a),
        .errSticky_o  (errSticky_a),
        .locked_o     (locked_a)
    );

    i2s_tdm_rx #(
        .DATA_WIDTH (24),
        .SLOT_WIDTH (32),
        .NUM_CH     (4),
        .MODE       (1),
        .WS_EDGE    (1)
    ) dut_b (
        .sclk_i       (sclk),
        .rst_i        (rst_b),
        .ws_i         (ws_b),
        .sdata_i      (sd_b),
        .clrErr_i     (clr_b),
        .chData_o     (chData_b),
        .frameValid_o (frameValid_b),
        .frameErr_o   (frameErr_b),
        .errSticky_o  (errSticky_b),
        .locked_o     (locked_b)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic [15:0] c0;
        logic [15:0] c1;
        int          len;
        int          rst_at;
        int          clr_at;
        logic        v;
        logic        e;
        logic        s;
        logic        l;
        logic [31:0] d;
    } row_a_t;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic        v;
        logic        l;
        logic [95:0] d;
    } row_b_t;

    row_a_t ta[11];
    row_b_t tb[3];

    int n_run  = 0;
    int n_fail = 0;
    int nv_a   = 0;
    int ne_a   = 0;
    int nv_b   = 0;
    int ev_a;
    int ee_a;
    int errs;

    logic        lsb_a;
    logic        obs_v, obs_e, obs_s, obs_l;
    logic [31:0] obs_d;
    logic        obs_vb, obs_lb;
    logic [95:0] obs_db;

    always @(negedge sclk) begin
        if (frameValid_a) nv_a++;
        if (frameErr_a)   ne_a++;
        if (frameValid_b) nv_b++;
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_a(input int n, input logic ws);
        for (int i = 0; i < n; i++) begin
            @(negedge sclk);
            ws_a  = ws;
            sd_a  = 1'b0;
            rst_a = 1'b0;
            clr_a = 1'b0;
        end
    endtask

    // One I2S frame: cycle 0 is the falling ws edge carrying the previous LSB
    task automatic frame_a(input logic [15:0] c0, input logic [15:0] c1,
                           input int len, input int rst_at, input int clr_at);
        logic [31:0] w;
        w = {c0, c1};
        for (int i = 0; i < len; i++) begin
            @(negedge sclk);
            if (i == 1) begin
                obs_v = frameValid_a;
                obs_e = frameErr_a;
                obs_s = errSticky_a;
                obs_l = locked_a;
                obs_d = chData_a;
            end
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("rst_outputs_zero",
                      128'({chData_a, frameValid_a, frameErr_a,
                            errSticky_a, locked_a}), '0);
            end
            ws_a  = (i < 16) ? 1'b0 : 1'b1;
            sd_a  = (i == 0) ? lsb_a : w[32-i];
            rst_a = (i == rst_at);
            clr_a = (i == clr_at);
        end
        lsb_a = w[0];
    endtask

    task automatic frame_b(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        logic [127:0] f;
        f = {w0, w1, w2, w3};
        for (int i = 0; i < 128; i++) begin
            @(negedge sclk);
            if (i == 1) begin
                obs_vb = frameValid_b;
                obs_lb = locked_b;
                obs_db = chData_b;
            end
            ws_b = (i == 0);
            sd_b = f[127-i];
        end
    endtask

    initial begin
        ta[0]  = '{16'hA5C3, 16'h1234, 32, -1, -1,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        ta[1]  = '{16'hA5C3, 16'h1234, 32, -1, -1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h1234A5C3};
        ta[2]  = '{16'hBEEF, 16'h0F0F, 32, -1, -1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h1234A5C3};
        ta[3]  = '{16'h1111, 16'h2222, 31, -1, -1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h0F0FBEEF};
        ta[4]  = '{16'h3333, 16'h4444, 32, -1, 5,
                   1'b0, 1'b1, 1'b1, 1'b0, 32'h0F0FBEEF};
        ta[5]  = '{16'h5555, 16'hAAAA, 32, -1, -1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h44443333};
        ta[6]  = '{16'h1357, 16'h2468, 31, -1, -1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA5555};
        ta[7]  = '{16'h0001, 16'h8000, 32, -1, 0,
                   1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA5555};
        ta[8]  = '{16'hCAFE, 16'hF00D, 32, 10, -1,
                   1'b1, 1'b0, 1'b1, 1'b1, 32'h80000001};
        ta[9]  = '{16'h9999, 16'h7777, 32, -1, -1,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        ta[10] = '{16'h2BAD, 16'hC0DE, 32, -1, -1,
                   1'b1, 1'b0, 1'b0, 1'b1, 32'h77779999};

        tb[0] = '{32'h123456A9, 32'hABCDEF5E, 32'h000001FF, 32'hFFFFFF00,
                  1'b0, 1'b0, 96'h0};
        tb[1] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
                  1'b1, 1'b1, 96'hFFFFFF_000001_ABCDEF_123456};
        tb[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                  1'b1, 1'b1, 96'hDDEEFF_99AABB_556677_112233};

        rst_a = 1'b1; ws_a = 1'b1; sd_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; ws_b = 1'b0; sd_b = 1'b0; clr_b = 1'b0;
        lsb_a = 1'b0;

        @(negedge sclk);
        check("reset_a", 128'({chData_a, frameValid_a, frameErr_a,
                               errSticky_a, locked_a}), '0);
        check("reset_b", 128'({chData_b, frameValid_b, frameErr_b,
                               errSticky_b, locked_b}), '0);
        rst_a = 1'b0;
        idle_a(2, 1'b1);

        ev_a = 3;
        ee_a = 1;
        for (int r = 0; r < 11; r++) begin
            frame_a(ta[r].c0, ta[r].c1, ta[r].len, ta[r].rst_at, ta[r].clr_at);
            check($sformatf("a_r%0d_valid", r), 128'(obs_v), 128'(ta[r].v));
            check($sformatf("a_r%0d_err", r), 128'(obs_e), 128'(ta[r].e));
            check($sformatf("a_r%0d_sticky", r), 128'(obs_s), 128'(ta[r].s));
            check($sformatf("a_r%0d_locked", r), 128'(obs_l), 128'(ta[r].l));
            check($sformatf("a_r%0d_data", r), 128'(obs_d), 128'(ta[r].d));
            ev_a += int'(ta[r].v);
            ee_a += int'(ta[r].e);
        end

        // ws stuck low after a good closing edge
        @(negedge sclk);
        ws_a = 1'b0;
        sd_a = lsb_a;
        errs = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge sclk);
            if (j == 1) begin
                check("stuck_close_valid", 128'(frameValid_a), 128'(1));
                check("stuck_close_data", 128'(chData_a), 128'(32'hC0DE2BAD));
            end
            if (j == 33) begin
                check("stuck_err_cycle33", 128'(frameErr_a), 128'(1));
            end
            if (frameErr_a) errs++;
            ws_a = 1'b0;
            sd_a = 1'b0;
        end
        check("stuck_err_once", 128'(errs), 128'(1));
        check("stuck_locked", 128'(locked_a), 128'(0));
        check("stuck_sticky", 128'(errSticky_a), 128'(1));

        idle_a(3, 1'b1);
        frame_a(16'h1234, 16'h5678, 32, -1, -1);
        check("resync_fe1_valid", 128'(obs_v), 128'(0));
        frame_a(16'h0F1E, 16'h2D3C, 32, -1, -1);
        check("resync_fe2_valid", 128'(obs_v), 128'(1));
        check("resync_fe2_data", 128'(obs_d), 128'(32'h56781234));
        check("resync_fe2_locked", 128'(obs_l), 128'(1));
        frame_a(16'h0000, 16'h0000, 32, -1, -1);
        check("resync_fe3_data", 128'(obs_d), 128'(32'h2D3C0F1E));
        idle_a(2, 1'b1);
        check("a_valid_pulses", 128'(nv_a), 128'(ev_a));
        check("a_err_pulses", 128'(ne_a), 128'(ee_a));

        @(negedge sclk);
        rst_b = 1'b0;
        ws_b  = 1'b0;
        @(negedge sclk);
        @(negedge sclk);
        for (int r = 0; r < 3; r++) begin
            frame_b(tb[r].w0, tb[r].w1, tb[r].w2, tb[r].w3);
            check($sformatf("b_r%0d_valid", r), 128'(obs_vb), 128'(tb[r].v));
            check($sformatf("b_r%0d_locked", r), 128'(obs_lb), 128'(tb[r].l));
            check($sformatf("b_r%0d_data", r), 128'(obs_db), 128'(tb[r].d));
        end
        check("b_valid_pulses", 128'(nv_b), 128'(2));
        check("b_no_err", 128'({frameErr_b, errSticky_b}), '0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_rx.md
Name: i2s_tdm_rx

Overview:
Parametrised serial audio receiver that replaces the fixed 16-bit stereo receiver at the front of the effect chain. It supports configurable data width, slot width, channel count (stereo I2S or TDM up to 8 slots) and framing mode (I2S one-bit delay or left-justified). It deserialises a full frame, publishes all channels together with a one-cycle valid strobe, and flags malformed frames. Its output feeds the DSP packet input directly.

Parameters:
DATA_WIDTH, 16, captured bits per channel (8..32), MSB-first; must be <= SLOT_WIDTH
SLOT_WIDTH, 16, sclk cycles per channel slot (8..32); bits beyond DATA_WIDTH are ignored
NUM_CH, 2, slots per frame (2..8); slot 0 is the first slot after the frame edge
MODE, 0, 0 = I2S (MSB one sclk after frame edge), 1 = left-justified (MSB on frame-edge cycle)
WS_EDGE, 0, frame-start edge of ws_i: 0 = falling (standard I2S, left low), 1 = rising (TDM pulse)

Ports:
sclk_i  in  1  bit clock, sole clock; all inputs sampled on rising edge
rst_i  in  1  synchronous reset, active-high
ws_i  in  1  word select / frame sync
sdata_i  in  1  serial data
clrErr_i  in  1  clears errSticky_o
chData_o  out  NUM_CH*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
frameValid_o  out  1  one-cycle strobe; chData_o updated this cycle
frameErr_o  out  1  one-cycle strobe on malformed frame
errSticky_o  out  1  set by any frameErr_o, held until clrErr_i or reset
locked_o  out  1  high after first good frame, low after error/reset

Behaviour:
- Reset: all outputs 0, wsQ <= 0, FSM to SYNC, counters 0, shift registers 0.
- Frame edge (FE): wsQ != ws_i in WS_EDGE direction; wsQ registered every cycle. Other ws edges ignored.
- FRAME_LEN = NUM_CH*SLOT_WIDTH. Period counter counts cycles since the last FE and saturates at FRAME_LEN+1. Its width is $clog2(FRAME_LEN+2).
- Bit position p in the frame: MODE 0, p = 0 on the cycle after FE; MODE 1, p = 0 on the FE cycle. Slot = p / SLOT_WIDTH, bit = p % SLOT_WIDTH. If bit < DATA_WIDTH, shift sdata_i into that slot's DATA_WIDTH bits, MSB first. p >= FRAME_LEN captures nothing.
- FSM SYNC: discard data. On FE: clear counters, go to RUN. No strobes.
- FSM RUN, on each FE:
  - period == FRAME_LEN: on the next cycle, chData_o <= captured frame, frameValid_o = 1, locked_o = 1.
  - Otherwise (short or long frame): discard frame, chData_o holds, frameErr_o = 1 on the next cycle, errSticky_o = 1, locked_o = 0. Stay in RUN and restart counting from this FE.
  - MODE 0: the FE-cycle bit is the last bit of the previous frame. It is captured before the restart.
- RUN long frame: if period reaches FRAME_LEN+1 with no FE, raise the error once, locked_o = 0, go to SYNC.
- Latency: frameValid_o rises 1 cycle after the FE that closes the frame. chData_o is stable between strobes.
- Simultaneous clrErr_i and a new error: the error wins, errSticky_o = 1.
- Reset mid-frame: the partial frame is lost and the block returns to SYNC. The first frame after reset is never published.
- The slot shift register is reused per frame. The published copy is a separate output register.

Test Plan:
1. Defaults, MODE 0. Send frames with ch0 = 0xA5C3, ch1 = 0x1234. After the 2nd FE, expect chData_o = 0x1234A5C3, one frameValid_o pulse per frame, locked_o = 1, no errors.
2. MODE 1, NUM_CH = 4, SLOT_WIDTH = 32, DATA_WIDTH = 24, WS_EDGE = 1, one-cycle ws pulse. Slots 0x123456xx, 0xABCDEFxx, 0x000001xx, 0xFFFFFFxx (xx = junk). Expect chData_o = 0xFFFFFF_000001_ABCDEF_123456.
3. Short frame: FE after 31 cycles (defaults). Expect frameErr_o pulse, errSticky_o = 1, locked_o = 0, chData_o unchanged. The next 32-cycle frame publishes normally.
4. ws stuck after lock. Expect exactly one frameErr_o at cycle 33 after the last FE, then the FSM is in SYNC. Resumed framing gives its first frameValid_o only after 2 FEs.
5. Assert rst_i for 1 cycle mid-frame. All outputs are 0 on the next cycle, and the first post-reset frame is not published. Separately, pulse clrErr_i on the same cycle as a new error: errSticky_o stays 1.
